// File: rtl/johnson8_pkg.sv
// Shared definitions for the 8-step Johnson sequencer run/stop controller:
// state encoding, ring codes for each phase and a phase-to-code helper.
package johnson8_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [3:0] J_PH0 = 4'b0000;
   localparam logic [3:0] J_PH1 = 4'b0001;
   localparam logic [3:0] J_PH2 = 4'b0011;
   localparam logic [3:0] J_PH3 = 4'b0111;
   localparam logic [3:0] J_PH4 = 4'b1111;
   localparam logic [3:0] J_PH5 = 4'b1110;
   localparam logic [3:0] J_PH6 = 4'b1100;
   localparam logic [3:0] J_PH7 = 4'b1000;
   localparam logic [3:0] J_EOR = 4'b1000;

   function automatic logic [3:0] phase_code(input logic [2:0] ph);
      logic [3:0] code;
      case (ph)
         3'd0:    code = J_PH0;
         3'd1:    code = J_PH1;
         3'd2:    code = J_PH2;
         3'd3:    code = J_PH3;
         3'd4:    code = J_PH4;
         3'd5:    code = J_PH5;
         3'd6:    code = J_PH6;
         default: code = J_PH7;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/johnson8_phase_chk.sv
// Integrity checker: tracks the phase the sequencer should be in and flags
// any cycle where the observed ring state disagrees.
module johnson8_phase_chk
   import johnson8_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       check_en,
   input  logic [3:0] dff4,
   output logic       mismatch
);

   logic [2:0] exp_ph_q;
   logic [2:0] exp_ph_d;
   logic [3:0] exp_code;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_ph_q <= 3'd0;
      end else begin
         exp_ph_q <= exp_ph_d;
      end
   end

   // Outside RUN the sequencer is held, so its only legal code is phase 0.
   always_comb begin
      exp_ph_d = run ? exp_ph_q + 3'd1 : 3'd0;
      exp_code = run ? phase_code(exp_ph_q) : J_PH0;
      mismatch = check_en && (dff4 != exp_code);
   end

endmodule

// File: rtl/johnson8_ctrl.sv
// Run/stop controller for the 8-step Johnson sequencer; always parks it at phase 0.
// Optional ring-state integrity checking is enabled with JOHNSON8_CTRL_CHECK_EN.
module johnson8_ctrl
   import johnson8_pkg::*;
#(
   parameter int ROUND_W = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               CMD_VALID,
   output logic               CMD_READY,
   input  logic [ROUND_W-1:0] CMD_ROUNDS,
   input  logic               STOP,
   input  logic               CLR_ERR,
   input  logic [3:0]         DFF4,
   output logic               SEQ_RUN,
   output logic               BUSY,
   output logic               ROUND_TICK,
   output logic               DONE,
   output logic [ROUND_W-1:0] ROUNDS_DONE,
   output logic               ERR
);

   state_t               state_q, state_d;
   logic                 seq_run_q, seq_run_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 round_tick_q, round_tick_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 stop_pending_q, stop_pending_d;
   logic [ROUND_W-1:0]   remaining_q, remaining_d;
   logic [ROUND_W-1:0]   rounds_done_q, rounds_done_d;
   logic                 eor;
   logic                 finish_now;

`ifdef JOHNSON8_CTRL_CHECK_EN
   logic phase_err;

   johnson8_phase_chk u_phase_chk (
      .clk      (CLK),
      .rst      (RESET),
      .run      (state_q == ST_RUN),
      .check_en (state_q != ST_FAULT),
      .dff4     (DFF4),
      .mismatch (phase_err)
   );
`else
   logic unused_clr_err;
   assign unused_clr_err = CLR_ERR;
`endif

   assign eor        = seq_run_q && (DFF4 == J_EOR);
   assign finish_now = (remaining_q == ROUND_W'(1)) || stop_pending_q || STOP;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q        <= ST_IDLE;
         seq_run_q      <= 1'b0;
         cmd_ready_q    <= 1'b0;
         round_tick_q   <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         stop_pending_q <= 1'b0;
         remaining_q    <= '0;
         rounds_done_q  <= '0;
      end else begin
         state_q        <= state_d;
         seq_run_q      <= seq_run_d;
         cmd_ready_q    <= cmd_ready_d;
         round_tick_q   <= round_tick_d;
         done_q         <= done_d;
         err_q          <= err_d;
         stop_pending_q <= stop_pending_d;
         remaining_q    <= remaining_d;
         rounds_done_q  <= rounds_done_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      remaining_d    = remaining_q;
      rounds_done_d  = rounds_done_q;
      stop_pending_d = stop_pending_q;
      round_tick_d   = 1'b0;
      done_d         = 1'b0;
      err_d          = err_q;
      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID && cmd_ready_q) begin
               state_d        = ST_RUN;
               remaining_d    = CMD_ROUNDS;
               rounds_done_d  = '0;
               stop_pending_d = 1'b0;
            end
         end
         ST_RUN: begin
            // Stops only take effect at a round boundary so rounds are never cut short.
            if (eor) begin
               round_tick_d = 1'b1;
               if (rounds_done_q != '1) begin
                  rounds_done_d = rounds_done_q + ROUND_W'(1);
               end
               if (finish_now) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else if (remaining_q != '0) begin
                  remaining_d = remaining_q - ROUND_W'(1);
               end
            end else if (STOP) begin
               stop_pending_d = 1'b1;
            end
         end
         ST_FAULT: begin
`ifdef JOHNSON8_CTRL_CHECK_EN
            if (CLR_ERR) begin
               state_d = ST_IDLE;
               err_d   = 1'b0;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef JOHNSON8_CTRL_CHECK_EN
      // A ring-state mismatch overrides any round completion in the same cycle.
      if (phase_err) begin
         state_d        = ST_FAULT;
         err_d          = 1'b1;
         round_tick_d   = 1'b0;
         done_d         = 1'b0;
         remaining_d    = remaining_q;
         rounds_done_d  = rounds_done_q;
         stop_pending_d = stop_pending_q;
      end
`endif
   end

   always_comb begin
      seq_run_d   = (state_d == ST_RUN);
      cmd_ready_d = (state_d == ST_IDLE);
   end

   assign SEQ_RUN     = seq_run_q;
   assign CMD_READY   = cmd_ready_q;
   assign BUSY        = (state_q == ST_RUN);
   assign ROUND_TICK  = round_tick_q;
   assign DONE        = done_q;
   assign ROUNDS_DONE = rounds_done_q;
   assign ERR         = err_q;

endmodule

// File: tb/tb_johnson8_ctrl.sv
// Bench for johnson8_ctrl driving a behavioural Johnson sequencer; outputs are
// checked every cycle against a cycles-since-accept model plus literal spot checks.
module tb_johnson8_ctrl;

   localparam int RW  = 8;
   localparam int INF = 1 << 24;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          stop = 1'b0;
   logic          clr_err = 1'b0;
   logic          force_bad = 1'b0;
   logic [RW-1:0] cmd_rounds = '0;
   logic          cmd_ready, seq_run, busy, round_tick, done, err;
   logic [RW-1:0] rounds_done;
   logic [3:0]    seq_q = 4'b0000;
   logic [3:0]    dff4_in;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Sequencer: SEQ_RUN low asynchronously holds the ring at 0000.
   always @(posedge clk or negedge seq_run) begin
      if (!seq_run) seq_q <= 4'b0000;
      else          seq_q <= {seq_q[2:0], ~seq_q[3]};
   end

   assign dff4_in = force_bad ? 4'b0101 : seq_q;

   johnson8_ctrl #(.ROUND_W(RW)) dut (
      .CLK         (clk),
      .RESET       (rst),
      .CMD_VALID   (cmd_valid),
      .CMD_READY   (cmd_ready),
      .CMD_ROUNDS  (cmd_rounds),
      .STOP        (stop),
      .CLR_ERR     (clr_err),
      .DFF4        (dff4_in),
      .SEQ_RUN     (seq_run),
      .BUSY        (busy),
      .ROUND_TICK  (round_tick),
      .DONE        (done),
      .ROUNDS_DONE (rounds_done),
      .ERR         (err)
   );

   // Model: a command is "cycle j after its accept edge" with T target rounds.
   bit m_has;
   bit m_rdy;
   int m_j;
   int m_t;

   function automatic logic [3:0] ring(input int p);
      logic [7:0] v;
      if (p <= 4) v = 8'((1 << p) - 1);
      else        v = 8'(8'h0F << (p - 4));
      return v[3:0];
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic bit m_running();
      return m_has && (m_j < 8 * m_t);
   endfunction

   function automatic int m_rounds();
      if (!m_has) return 0;
      return imin(imin(m_j, 8 * m_t) / 8, (1 << RW) - 1);
   endfunction

   function automatic bit m_tick();
      return m_has && (m_j > 0) && (m_j % 8 == 0) && (m_j <= 8 * m_t);
   endfunction

   task automatic model_reset();
      m_has = 0; m_rdy = 0; m_j = 0; m_t = 0;
   endtask

   task automatic model_edge();
      if (m_running()) begin
         if (stop) m_t = imin(m_t, m_j / 8 + 1);
         m_j++;
      end else if (m_rdy && cmd_valid) begin
         m_has = 1;
         m_j   = 0;
         m_t   = (cmd_rounds == 0) ? INF : int'(cmd_rounds);
      end else if (m_has && m_j <= 8 * m_t) begin
         m_j++;
      end
      m_rdy = 1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic compare();
      check("seq_run", int'(seq_run), int'(m_running()));
      check("busy", int'(busy), int'(m_running()));
      check("cmd_ready", int'(cmd_ready), int'(m_rdy && !m_running()));
      check("round_tick", int'(round_tick), int'(m_tick()));
      check("done", int'(done), int'(m_has && m_j == 8 * m_t));
      check("rounds_done", int'(rounds_done), m_rounds());
      check("err", int'(err), 0);
      check("dff4", int'(seq_q), m_running() ? int'(ring(m_j % 8)) : 0);
   endtask

   int         hi_cnt;
   bit         saw_done;
   bit         cap_on;
   logic [3:0] cap[$];

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
      if (seq_run) hi_cnt++;
      if (done) begin
         saw_done = 1;
         check("tick_with_done", int'(round_tick), 1);
      end
      if (cap_on) cap.push_back(seq_q);
   endtask

   task automatic send(input int n);
      cmd_valid  = 1'b1;
      cmd_rounds = RW'(n);
      saw_done   = 0;
      hi_cnt     = 0;
      step();
      cmd_valid  = 1'b0;
      check("accepted", int'(busy), 1);
      check("rounds_cleared", int'(rounds_done), 0);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!saw_done && k < budget) begin
         step();
         k++;
      end
      check("done_timeout", int'(saw_done), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      compare();
      step();
      check("ready_after_reset", int'(cmd_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_seq[9];
      exp_seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
      model_reset();
      hi_cnt = 0; saw_done = 0; cap_on = 0;

      // Reset values while RESET is held.
      #1;
      compare();
      check("reset_ready_low", int'(cmd_ready), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      compare();
      step();
      check("ready_first_edge", int'(cmd_ready), 1);

      // One round: 8 cycles high, ring walks 0001..1000 then parks.
      cap_on = 1;
      send(1);
      wait_done(40);
      cap_on = 0;
      check("r1_high_cycles", hi_cnt, 8);
      check("r1_rounds_done", int'(rounds_done), 1);
      check("r1_cap_len", cap.size(), 9);
      for (int i = 0; i < 9 && i < cap.size(); i++)
         check($sformatf("r1_ring_%0d", i), int'(cap[i]), int'(exp_seq[i]));

      // Back-to-back: accept on the edge right after DONE.
      send(3);
      wait_done(60);
      check("r3_high_cycles", hi_cnt, 24);
      check("r3_rounds_before_accept", int'(rounds_done), 3);
      send(2);
      check("b2b_running", int'(seq_run), 1);
      wait_done(40);
      check("r2_high_cycles", hi_cnt, 16);

      // Continuous, STOP at phase 3 of round 5.
      send(0);
      repeat (35) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done(40);
      check("stop_mid_high", hi_cnt, 40);
      check("stop_mid_rounds", int'(rounds_done), 5);

      // Continuous, STOP on the EOR cycle of round 2.
      send(0);
      repeat (15) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done(40);
      check("stop_eor_high", hi_cnt, 16);
      check("stop_eor_rounds", int'(rounds_done), 2);

      // RESET at phase 4 of round 2 of a 4-round command.
      send(4);
      repeat (12) step();
      check("pre_reset_ring", int'(seq_q), 15);
      #2;
      rst = 1'b1;
      #1;
      check("rst_seq_run", int'(seq_run), 0);
      check("rst_ring", int'(seq_q), 0);
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(cmd_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      compare();
      step();
      check("ready_after_release", int'(cmd_ready), 1);

      // Counter saturation on a long continuous run, then all-ones rounds.
      send(0);
      repeat (2075) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done(20);
      check("sat_high", hi_cnt, 2080);
      check("sat_rounds", int'(rounds_done), 255);
      send(255);
      wait_done(2100);
      check("max_high", hi_cnt, 2040);
      check("max_rounds", int'(rounds_done), 255);

      // Corrupt ring state for one cycle mid-round.
      send(2);
      repeat (2) step();
      force_bad = 1'b1;
`ifdef JOHNSON8_CTRL_CHECK_EN
      @(negedge clk);
      force_bad = 1'b0;
      check("fault_err", int'(err), 1);
      check("fault_seq_run", int'(seq_run), 0);
      check("fault_ready", int'(cmd_ready), 0);
      cmd_valid = 1'b1;
      cmd_rounds = RW'(1);
      repeat (3) begin
         @(negedge clk);
         check("fault_hold_err", int'(err), 1);
         check("fault_hold_run", int'(seq_run), 0);
         check("fault_no_done", int'(done), 0);
      end
      cmd_valid = 1'b0;
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("clr_err", int'(err), 0);
      check("clr_ready", int'(cmd_ready), 1);
      do_reset();
`else
      step();
      force_bad = 1'b0;
      check("nochk_err", int'(err), 0);
      wait_done(40);
      check("nochk_high", hi_cnt, 16);
`endif

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         cmd_valid  = ($urandom_range(0, 2) == 0);
         cmd_rounds = RW'($urandom_range(0, 4));
         stop       = ($urandom_range(0, 29) == 0);
         step();
         if (saw_done) begin
            $display("txn done at %0t rounds=%0d", $time, rounds_done);
            saw_done = 0;
         end
      end
      cmd_valid = 1'b0;
      stop = 1'b1;
      for (int k = 0; k < 40 && m_running(); k++) step();
      stop = 1'b0;
      check("final_idle", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
